// File: rtl/kule_spi_pkg.sv
// rtl/kule_spi_pkg.sv - opcodes, FSM states and draw command record for the MCU->FPGA SPI link
package kule_spi_pkg;

  localparam logic [7:0] OP_SPRITE_LOAD = 8'h00;
  localparam logic [7:0] OP_DRAW        = 8'h01;
  localparam logic [7:0] TERM_BYTE      = 8'h00;

  localparam int CMD_ID_W    = 8;
  localparam int CMD_COORD_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DISCARD,
    ST_SPR_ID,
    ST_SPR_PIX,
    ST_SPR_TERM,
    ST_DRW_ID,
    ST_X_HI,
    ST_X_LO,
    ST_Y_HI,
    ST_Y_LO,
    ST_SCALE,
    ST_DRW_TERM
  } state_t;

  typedef struct packed {
    logic [CMD_ID_W-1:0]    id;
    logic [CMD_COORD_W-1:0] x;
    logic [CMD_COORD_W-1:0] y;
    logic [7:0]             scale;
  } draw_cmd_t;

endpackage

// File: rtl/spi_byte_slave.sv
// rtl/spi_byte_slave.sv - oversampled SPI mode-3 slave: byte assembly and previous-byte echo on miso
module spi_byte_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       cs,
  input  logic       mosi,
  output logic       cs_active,
  output logic       byte_done,
  output logic [7:0] byte_data,
  output logic       miso
);

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic       sck_prev;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [7:0] tx;
  logic       sck_s, mosi_s, sck_rise, sck_fall;

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_active = !cs_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s && !sck_prev;
  assign sck_fall  = !sck_s && sck_prev;

  // sck and cs synchronisers reset to their idle-high level so no false edge follows reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '1;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b1;
      bit_cnt   <= 3'd0;
      shift     <= 7'd0;
      tx        <= 8'd0;
      byte_data <= 8'd0;
      byte_done <= 1'b0;
      miso      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_prev  <= sck_s;
      byte_done <= 1'b0;
      if (!cs_active) begin
        bit_cnt <= 3'd0;
        tx      <= 8'd0;
        miso    <= 1'b0;
      end else begin
        if (sck_rise) begin
          shift   <= {shift[5:0], mosi_s};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_done <= 1'b1;
            byte_data <= {shift, mosi_s};
            tx        <= {shift, mosi_s};
          end
        end
        if (sck_fall) begin
          miso <= tx[7];
          tx   <= {tx[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/spi_cmd_receiver.sv
// rtl/spi_cmd_receiver.sv - SPI command decoder: SPRITE_LOAD to sprite RAM, DRAW to renderer handshake
module spi_cmd_receiver
  import kule_spi_pkg::*;
#(
  parameter int SPRITE_BYTES = 512,
  parameter int ID_W         = CMD_ID_W,
  parameter int COORD_W      = CMD_COORD_W,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               sys_clock,
  input  logic               reset_n,
  input  logic               spi_sck,
  input  logic               spi_cs,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic               spr_wr_en,
  output logic [ID_W-1:0]    spr_id,
  output logic [8:0]         spr_addr,
  output logic [7:0]         spr_data,
  output logic               draw_valid,
  input  logic               draw_ready,
  output logic [ID_W-1:0]    draw_id,
  output logic [COORD_W-1:0] draw_x,
  output logic [COORD_W-1:0] draw_y,
  output logic [7:0]         draw_scale,
  output logic               cmd_error
);

  localparam logic [9:0] LAST_PIX = 10'(SPRITE_BYTES - 1);

  state_t     state, next_state;
  logic       cs_active, byte_done;
  logic [7:0] byte_data;
  logic [9:0] pix;
  draw_cmd_t  shadow, draw_out;
  logic       wr_fire, commit, err;

  spi_byte_slave #(.SYNC_STAGES(SYNC_STAGES)) u_slave (
    .clk       (sys_clock),
    .rst_n     (reset_n),
    .sck       (spi_sck),
    .cs        (spi_cs),
    .mosi      (spi_mosi),
    .cs_active (cs_active),
    .byte_done (byte_done),
    .byte_data (byte_data),
    .miso      (spi_miso)
  );

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    wr_fire    = 1'b0;
    commit     = 1'b0;
    err        = 1'b0;
    if (!cs_active) begin
      next_state = ST_IDLE;
    end else if (byte_done) begin
      case (state)
        ST_IDLE: begin
          if (byte_data == OP_SPRITE_LOAD) next_state = ST_SPR_ID;
          else if (byte_data == OP_DRAW)   next_state = ST_DRW_ID;
          else begin
            err        = 1'b1;
            next_state = ST_DISCARD;
          end
        end
        ST_DISCARD: next_state = ST_DISCARD;
        ST_SPR_ID:  next_state = ST_SPR_PIX;
        ST_SPR_PIX: begin
          wr_fire = 1'b1;
          if (pix == LAST_PIX) next_state = ST_SPR_TERM;
        end
        ST_SPR_TERM: begin
          err        = (byte_data != TERM_BYTE);
          next_state = ST_IDLE;
        end
        ST_DRW_ID: next_state = ST_X_HI;
        ST_X_HI:   next_state = ST_X_LO;
        ST_X_LO:   next_state = ST_Y_HI;
        ST_Y_HI:   next_state = ST_Y_LO;
        ST_Y_LO:   next_state = ST_SCALE;
        ST_SCALE:  next_state = ST_DRW_TERM;
        ST_DRW_TERM: begin
          next_state = ST_IDLE;
          // a command arriving while the previous one is still stalled is dropped
          if (byte_data != TERM_BYTE || (draw_valid && !draw_ready)) err = 1'b1;
          else commit = 1'b1;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      pix        <= 10'd0;
      spr_wr_en  <= 1'b0;
      spr_id     <= '0;
      spr_addr   <= 9'd0;
      spr_data   <= 8'd0;
      shadow     <= '0;
      draw_out   <= '0;
      draw_valid <= 1'b0;
      cmd_error  <= 1'b0;
    end else begin
      spr_wr_en <= wr_fire;
      cmd_error <= err;
      if (wr_fire) begin
        spr_addr <= pix[8:0];
        spr_data <= byte_data;
        pix      <= pix + 10'd1;
      end
      if (cs_active && byte_done) begin
        case (state)
          ST_SPR_ID: begin
            spr_id <= ID_W'(byte_data);
            pix    <= 10'd0;
          end
          ST_DRW_ID: shadow.id       <= CMD_ID_W'(byte_data);
          ST_X_HI:   shadow.x[15:8]  <= byte_data;
          ST_X_LO:   shadow.x[7:0]   <= byte_data;
          ST_Y_HI:   shadow.y[15:8]  <= byte_data;
          ST_Y_LO:   shadow.y[7:0]   <= byte_data;
          ST_SCALE:  shadow.scale    <= byte_data;
          default: ;
        endcase
      end
      if (commit) begin
        draw_out   <= shadow;
        draw_valid <= 1'b1;
      end else if (draw_valid && draw_ready) begin
        draw_valid <= 1'b0;
      end
    end
  end

  assign draw_id    = ID_W'(draw_out.id);
  assign draw_x     = COORD_W'(draw_out.x);
  assign draw_y     = COORD_W'(draw_out.y);
  assign draw_scale = draw_out.scale;

endmodule

// File: tb/tb_spi_cmd_receiver.sv
// tb/tb_spi_cmd_receiver.sv - directed self-checking bench for spi_cmd_receiver
module tb_spi_cmd_receiver;

  logic        sys_clock = 1'b0;
  logic        reset_n, spi_sck, spi_cs, spi_mosi, spi_miso, draw_ready;
  logic        spr_wr_en, draw_valid, cmd_error;
  logic [7:0]  spr_id, spr_data, draw_id, draw_scale;
  logic [8:0]  spr_addr;
  logic [15:0] draw_x, draw_y;

  spi_cmd_receiver dut (
    .sys_clock  (sys_clock),
    .reset_n    (reset_n),
    .spi_sck    (spi_sck),
    .spi_cs     (spi_cs),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spr_wr_en  (spr_wr_en),
    .spr_id     (spr_id),
    .spr_addr   (spr_addr),
    .spr_data   (spr_data),
    .draw_valid (draw_valid),
    .draw_ready (draw_ready),
    .draw_id    (draw_id),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .draw_scale (draw_scale),
    .cmd_error  (cmd_error)
  );

  always #5 sys_clock = ~sys_clock;

  int checks = 0, errors = 0;
  int spr_cnt = 0, spr_bad = 0, mon_idx = 0, err_cnt = 0, hs_cnt = 0, vcyc = 0;
  logic [7:0]  mon_id = 8'd0, hs_id = 8'd0, hs_scale = 8'd0;
  logic [15:0] hs_x = 16'd0, hs_y = 16'd0;

  // strobes must walk addresses from mon_idx with data = address low byte
  always @(negedge sys_clock) begin
    if (spr_wr_en) begin
      if (spr_addr != mon_idx[8:0] || spr_data != mon_idx[7:0] || spr_id != mon_id) spr_bad++;
      mon_idx++;
      spr_cnt++;
    end
    if (cmd_error) err_cnt++;
    if (draw_valid) vcyc++;
    if (draw_valid && draw_ready) begin
      hs_cnt++;
      hs_id    = draw_id;
      hs_x     = draw_x;
      hs_y     = draw_y;
      hs_scale = draw_scale;
    end
  end

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  scale;
    logic [7:0]  term;
    int          exp_hs;
    int          exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clock);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_sck  = 1'b0;
      spi_mosi = b[i];
      tick(4);
      rx[i]    = spi_miso;
      spi_sck  = 1'b1;
      tick(4);
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] rx;
    spi_byte(b, rx);
  endtask

  task automatic cs_on();
    spi_cs = 1'b0;
    tick(4);
  endtask

  task automatic cs_off();
    tick(4);
    spi_cs = 1'b1;
    tick(6);
  endtask

  task automatic send_draw(input logic [7:0] op, input logic [7:0] id, input logic [15:0] x,
                           input logic [15:0] y, input logic [7:0] sc, input logic [7:0] term);
    send(op); send(id);
    send(x[15:8]); send(x[7:0]);
    send(y[15:8]); send(y[7:0]);
    send(sc); send(term);
  endtask

  initial begin
    int base_err, base_hs, base_vc, base_spr, base_bad;
    logic [7:0] r0, r1;

    vecs[0] = '{"draw_basic", 8'h01, 8'h02, 16'h0008, 16'h121A, 8'h02, 8'h00, 1, 0};
    vecs[1] = '{"draw_max",   8'h01, 8'h07, 16'hFFFF, 16'h0000, 8'hFF, 8'h00, 1, 0};
    vecs[2] = '{"draw_badterm", 8'h01, 8'h02, 16'h0008, 16'h121A, 8'h02, 8'h55, 0, 1};
    vecs[3] = '{"bad_opcode", 8'h7E, 8'h11, 16'h2222, 16'h3333, 8'h44, 8'h00, 0, 1};
    vecs[4] = '{"draw_mixed", 8'h01, 8'hA5, 16'h1234, 16'h5678, 8'h80, 8'h00, 1, 0};

    reset_n = 1'b0; spi_cs = 1'b1; spi_sck = 1'b1; spi_mosi = 1'b0; draw_ready = 1'b1;
    tick(3);
    chk("reset_outputs", {spi_miso, spr_wr_en, spr_id, spr_addr, spr_data, draw_valid, draw_id,
                          draw_scale, cmd_error}, 64'd0);
    chk("reset_coords", {draw_x, draw_y}, 64'd0);
    reset_n = 1'b1;
    tick(3);

    // full sprite load
    mon_idx = 0; mon_id = 8'h02; base_spr = spr_cnt; base_err = err_cnt;
    cs_on();
    send(8'h00); send(8'h02);
    for (int i = 0; i < 512; i++) send(8'(i));
    send(8'h00);
    cs_off();
    chk("sprite_strobes", 64'(spr_cnt - base_spr), 64'd512);
    chk("sprite_bad_strobes", 64'(spr_bad), 64'd0);
    chk("sprite_last_addr", 64'(spr_addr), 64'd511);
    chk("sprite_no_error", 64'(err_cnt - base_err), 64'd0);

    for (int v = 0; v < 5; v++) begin
      base_err = err_cnt; base_hs = hs_cnt; base_vc = vcyc;
      cs_on();
      send_draw(vecs[v].op, vecs[v].id, vecs[v].x, vecs[v].y, vecs[v].scale, vecs[v].term);
      cs_off();
      chk({vecs[v].name, "_handshakes"}, 64'(hs_cnt - base_hs), 64'(vecs[v].exp_hs));
      chk({vecs[v].name, "_valid_cycles"}, 64'(vcyc - base_vc), 64'(vecs[v].exp_hs));
      chk({vecs[v].name, "_errors"}, 64'(err_cnt - base_err), 64'(vecs[v].exp_err));
      if (vecs[v].exp_hs == 1)
        chk({vecs[v].name, "_fields"}, {hs_id, hs_x, hs_y, hs_scale},
            {vecs[v].id, vecs[v].x, vecs[v].y, vecs[v].scale});
    end

    // back-to-back draws with the renderer stalled
    draw_ready = 1'b0; base_err = err_cnt; base_hs = hs_cnt;
    cs_on();
    send_draw(8'h01, 8'h04, 16'h0100, 16'h0200, 8'h01, 8'h00);
    send_draw(8'h01, 8'h05, 16'h0300, 16'h0400, 8'h03, 8'h00);
    cs_off();
    chk("stall_drop_error", 64'(err_cnt - base_err), 64'd1);
    chk("stall_valid_held", {draw_valid, draw_id, draw_x, draw_y, draw_scale},
        {1'b1, 8'h04, 16'h0100, 16'h0200, 8'h01});
    chk("stall_no_handshake", 64'(hs_cnt - base_hs), 64'd0);
    draw_ready = 1'b1;
    tick(4);
    chk("stall_release_valid", 64'(draw_valid), 64'd0);
    chk("stall_release_hs", {32'(hs_cnt - base_hs), 24'd0, hs_id}, {32'd1, 24'd0, 8'h04});

    // cs abort after Y_HI, then a complete draw
    base_err = err_cnt; base_hs = hs_cnt;
    cs_on();
    send(8'h01); send(8'h09); send(8'h00); send(8'h10); send(8'h00);
    cs_off();
    cs_on();
    send_draw(8'h01, 8'h03, 16'h0020, 16'h0030, 8'h04, 8'h00);
    cs_off();
    chk("abort_handshakes", 64'(hs_cnt - base_hs), 64'd1);
    chk("abort_fields", {hs_id, hs_x, hs_y, hs_scale}, {8'h03, 16'h0020, 16'h0030, 8'h04});
    chk("abort_no_error", 64'(err_cnt - base_err), 64'd0);

    // miso echoes the previous byte of the same cs window
    base_err = err_cnt;
    cs_on();
    spi_byte(8'hA5, r0);
    spi_byte(8'h3C, r1);
    cs_off();
    chk("miso_first_byte", 64'(r0), 64'h00);
    chk("miso_echo", 64'(r1), 64'hA5);
    chk("miso_badop_error", 64'(err_cnt - base_err), 64'd1);

    // reset in the middle of a sprite load
    mon_idx = 0; mon_id = 8'h01; base_spr = spr_cnt;
    cs_on();
    send(8'h00); send(8'h01);
    for (int i = 0; i < 100; i++) send(8'(i));
    tick(4);
    chk("midload_strobes", 64'(spr_cnt - base_spr), 64'd100);
    chk("midload_addr", 64'(spr_addr), 64'd99);
    spi_sck = 1'b0; spi_mosi = 1'b1;
    tick(2);
    reset_n = 1'b0;
    #1;
    chk("midload_reset_sprite", {spi_miso, spr_wr_en, spr_id, spr_addr, spr_data, cmd_error}, 64'd0);
    chk("midload_reset_draw", {draw_valid, draw_id, draw_x, draw_y, draw_scale}, 64'd0);
    tick(2);
    spi_sck = 1'b1; spi_cs = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(3);
    mon_idx = 0; mon_id = 8'h06; base_spr = spr_cnt; base_bad = spr_bad;
    cs_on();
    send(8'h00); send(8'h06);
    for (int i = 0; i < 3; i++) send(8'(i));
    cs_off();
    chk("reload_strobes", 64'(spr_cnt - base_spr), 64'd3);
    chk("reload_from_zero", 64'(spr_bad - base_bad), 64'd0);
    chk("reload_last_addr", {spr_id, 7'd0, spr_addr}, {8'h06, 7'd0, 9'd2});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
